prog_timer_counter: RTL

- Parametrised, loadable timer/counter; successor to the fixed 4-bit loadable counter.
- Adds configurable width, prescaler, up/down direction, one-shot vs auto-reload mode, start/stop control and a one-cycle terminal-count pulse.
- Used as the CPU's general-purpose interval timer and as a programmable clock-enable divider for slower peripherals.

---
 rtl/prog_timer_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/prog_timer_counter.sv
// Programmable interval timer/counter: loadable reload value, prescaler, up/down,
// one-shot or auto-reload, start/stop control and a one-cycle terminal-count pulse.
module prog_timer_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               start,
  input  logic               stop,
  input  logic               dir_down,
  input  logic               mode_reload,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   count,
  output logic               running,
  output logic               tc
);

  logic [WIDTH-1:0]   reload_reg;
  logic [PRESC_W-1:0] presc_cnt;

  logic [WIDTH-1:0]   count_n;
  logic [WIDTH-1:0]   reload_n;
  logic [PRESC_W-1:0] presc_n;
  logic               running_n;
  logic               tc_n;

  logic tick;
  logic terminal;

  // >= rather than == so that lowering prescale mid-run cannot skip the wrap.
  assign tick     = running && (presc_cnt >= prescale);
  assign terminal = dir_down ? (count == '0) : (count == reload_reg);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    count_n   = count;
    reload_n  = reload_reg;
    presc_n   = presc_cnt;
    running_n = running;
    tc_n      = 1'b0;

    if (load) begin
      reload_n  = load_val;
      count_n   = dir_down ? load_val : '0;
      presc_n   = '0;
      running_n = 1'b0;
    end else begin
      // A tick due on a stop edge is still applied; otherwise stop freezes the phase.
      if (running) begin
        if (tick)
          presc_n = '0;
        else if (!stop)
          presc_n = presc_cnt + 1'b1;
      end

      if (tick) begin
        if (terminal) begin
          tc_n = 1'b1;
          if (mode_reload)
            count_n = dir_down ? reload_reg : '0;
          else
            running_n = 1'b0;
        end else begin
          count_n = dir_down ? (count - 1'b1) : (count + 1'b1);
        end
      end

      if (stop)
        running_n = 1'b0;
      else if (start && !running)
        running_n = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      reload_reg <= '0;
      presc_cnt  <= '0;
      running    <= 1'b0;
      tc         <= 1'b0;
    end else begin
      count      <= count_n;
      reload_reg <= reload_n;
      presc_cnt  <= presc_n;
      running    <= running_n;
      tc         <= tc_n;
    end
  end

endmodule
